clk_div_ctrl: RTL and testbench

Programmable clock-enable controller for the 100 MHz system clock domain. It derives a divided pixel strobe (`en_out`) and a divided square wave (`clk_out`) from `clk_in`. It accepts divisor changes over a valid/ready handshake and applies them only at a period boundary, so no short or runt period is ever produced. It reports `locked` once the new rate has been stable for a set number of periods. It sits between the top-level reset/button logic and the video timing generator, which consumes `en_out` as its pixel enable.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_core.sv | 39 +++
 rtl/clk_div_ctrl.sv | 133 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants
// for the clock-enable controller
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP,
    SETTLE,
    RUN,
    PEND
  } state_t;

  localparam int DIV_25MHZ        = 4;
  localparam int DIV_50MHZ        = 2;
  localparam int LOCK_PERIODS_DEF = 4;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with
// terminal-count, strobe and square-wave decode
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             act,
  input  logic [CNT_W-1:0] div,
  output logic             tc,
  output logic             en_out,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W:0]   half;

  assign last    = div - 1'b1;
  assign half    = ({1'b0, div} + 1'b1) >> 1;
  assign tc      = act && (cnt == last);
  assign en_out  = tc;
  assign clk_out = act && ({1'b0, cnt} < half);

  // count while running; clear when idle or at the end of a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt >= last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: divisor handshake, boundary-safe
// rate change and lock tracking around clk_div_core
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = DIV_25MHZ,
  parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             en_out,
  output logic             clk_out,
  output logic             locked,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(LOCK_PERIODS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] pend_div, pend_nx;
  logic [CNT_W-1:0] per_cnt, per_nx;
  logic [CNT_W-1:0] div_nx;
  logic             lock_nx, err_nx;
  logic             hs, bad, chg;
  logic             tc, act, run;

  // the counter only runs once the FSM has left STOP
  // and clears on the cycle it is sent back there
  assign act       = (state != STOP);
  assign run       = act && enable;
  assign cfg_ready = (state != PEND);
  assign hs        = cfg_valid && cfg_ready;
  assign bad       = (cfg_div < MIN_DIV);
  assign chg       = hs && !bad && (cfg_div != cur_div);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk_in),
    .rst_n   (rst),
    .run     (run),
    .act     (act),
    .div     (cur_div),
    .tc      (tc),
    .en_out  (en_out),
    .clk_out (clk_out)
  );

  // control state and divisor registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state    <= STOP;
      cur_div  <= DIV_RST;
      pend_div <= DIV_RST;
      per_cnt  <= '0;
      locked   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cur_div  <= div_nx;
      pend_div <= pend_nx;
      per_cnt  <= per_nx;
      locked   <= lock_nx;
      cfg_err  <= err_nx;
    end
  end

  // next state: stop overrides all, changes wait for a period end
  always_comb begin
    state_nx = state;
    div_nx   = cur_div;
    pend_nx  = pend_div;
    per_nx   = per_cnt;
    lock_nx  = locked;
    err_nx   = hs && bad;
    if (!enable) begin
      state_nx = STOP;
      per_nx   = '0;
      lock_nx  = 1'b0;
      if (state == PEND) begin
        div_nx = pend_div;
      end else if (chg) begin
        div_nx = cfg_div;
      end
    end else begin
      unique case (state)
        STOP: begin
          if (chg) div_nx = cfg_div;
          state_nx = SETTLE;
          per_nx   = '0;
          lock_nx  = 1'b0;
        end
        SETTLE: begin
          if (chg) begin
            pend_nx  = cfg_div;
            state_nx = PEND;
          end else if (tc) begin
            if (per_cnt >= PER_LAST) begin
              state_nx = RUN;
              lock_nx  = 1'b1;
            end else begin
              per_nx = per_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (chg) begin
            pend_nx  = cfg_div;
            state_nx = PEND;
          end
        end
        PEND: begin
          if (tc) begin
            div_nx   = pend_div;
            state_nx = SETTLE;
            per_nx   = '0;
            lock_nx  = 1'b0;
          end
        end
        default: state_nx = STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and random stimulus
// against a period-level reference model
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       en_out;
  logic       clk_out;
  logic       locked;
  logic [7:0] cur_div;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: rate, pending rate, position
  // inside the period, periods completed at this rate
  bit m_on;
  int m_div;
  int m_pend;
  int m_pos;
  int m_per;
  bit m_lock;
  bit m_err;

  localparam int L = 4;

  clk_div_ctrl dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .en_out    (en_out),
    .clk_out   (clk_out),
    .locked    (locked),
    .cur_div   (cur_div)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_on   = 0;
    m_div  = 4;
    m_pend = 0;
    m_pos  = 0;
    m_per  = 0;
    m_lock = 0;
    m_err  = 0;
  endfunction

  function automatic bit m_tc();
    return m_on && (m_pos == m_div - 1);
  endfunction

  // one clock edge of the reference behaviour
  function automatic void m_step(input bit e, input bit v, input int d);
    bit hs, ok, tc;
    hs = v && (m_pend == 0);
    ok = hs && (d >= 2) && (d != m_div);
    tc = m_tc();
    m_err = hs && (d < 2);
    if (!e) begin
      if (m_pend != 0) m_div = m_pend;
      else if (ok) m_div = d;
      m_pend = 0;
      m_on   = 0;
      m_pos  = 0;
      m_per  = 0;
      m_lock = 0;
    end else if (!m_on) begin
      if (ok) m_div = d;
      m_on   = 1;
      m_pos  = 0;
      m_per  = 0;
      m_lock = 0;
    end else begin
      if (tc) begin
        m_pos = 0;
        if (m_pend != 0) begin
          m_div  = m_pend;
          m_pend = 0;
          m_per  = 0;
          m_lock = 0;
        end else if (!ok) begin
          m_per++;
          if (m_per >= L) m_lock = 1;
        end
      end else begin
        m_pos++;
      end
      if (ok) m_pend = d;
    end
  endfunction

  task automatic check_all();
    chk("en_out", en_out, m_tc());
    chk("clk_out", clk_out, m_on && (m_pos < (m_div + 1) / 2));
    chk("locked", locked, m_lock);
    chk("cur_div", cur_div, m_div);
    chk("cfg_ready", cfg_ready, m_pend == 0);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic cyc(input bit e, input bit v, input int d);
    enable    = e;
    cfg_valid = v;
    cfg_div   = 8'(d);
    @(posedge clk_in);
    m_step(e, v, d);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  // reset pulse between edges; outputs must clear at once
  task automatic async_rst();
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("rst_en_out", en_out, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cur_div", cur_div, 4);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk_in);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    int tries;
    int d;
    bit e, v;
    rst       = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    m_reset();
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    check_all();

    // default rate, settle and lock
    idle(24);
    chk("lock_d4", locked, 1);

    // change to 6 mid-period
    cyc(1, 0, 0);
    cyc(1, 1, 6);
    idle(40);
    chk("lock_d6", locked, 1);

    // back to 4, then an invalid offer
    cyc(1, 1, 4);
    idle(30);
    cyc(1, 1, 1);
    idle(12);

    // offer 5 on a terminal count
    tries = 0;
    while (!m_tc() && tries < 20) begin
      cyc(1, 0, 0);
      tries++;
    end
    chk("tc_found", m_tc(), 1);
    cyc(1, 1, 5);
    idle(35);

    // drop enable while a divisor of 8 is pending
    cyc(1, 1, 8);
    cyc(0, 0, 0);
    chk("stop_cur_div", cur_div, 8);
    idle(40);

    // reset in the middle of settling
    cyc(0, 0, 0);
    idle(5);
    async_rst();
    idle(20);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1);
      else d = $urandom_range(2, 9);
      if ($urandom_range(0, 15) == 0) d = m_div;
      cyc(e, v, d);
      if ($urandom_range(0, 799) == 0) async_rst();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
